// File: rtl/toy_bus_mem_req_node_pkg.sv
// Shared ToyBus field widths, opcodes and the core-word to bus-byte address helper.
package toy_bus_mem_req_node_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 256;
    localparam int STRB_W   = 32;
    localparam int ID_W     = 4;
    localparam int SB_W     = 32;
    localparam int WORD_OFS = 5;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
        logic              opcode;
        logic [SB_W-1:0]   sideband;
    } req_payload_t;

    localparam int REQ_PAYLOAD_W = $bits(req_payload_t);

    // A core word is 32 bytes; only a 24-bit word index reaches the bus.
    function automatic logic [ADDR_W-1:0] word2byte(input logic [23:0] word_idx);
        return {3'b0, word_idx, {WORD_OFS{1'b0}}};
    endfunction

endpackage

// File: rtl/toy_bus_fwd_reg.sv
// One-entry valid/ready forward register; full throughput while the sink is ready.
module toy_bus_fwd_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_data_o
);

    logic         vld_q;
    logic [W-1:0] data_q;
    logic         load;

    assign in_rdy_o   = ~vld_q | out_rdy_i;
    assign load       = in_vld_i & in_rdy_o;
    assign out_vld_o  = vld_q;
    assign out_data_o = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (load) begin
            vld_q  <= 1'b1;
            data_q <= in_data_i;
        end else if (out_rdy_i) begin
            vld_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/toy_bus_mem_req_node.sv
// Core memory port to ToyBus initiator bridge: posted writes, credit-limited reads,
// in-order combinational read-ack pass-through.
module toy_bus_mem_req_node
    import toy_bus_mem_req_node_pkg::*;
#(
    parameter logic [3:0] NODE_ID         = 4'd1,
    parameter logic [3:0] TGT_ID          = 4'd0,
    parameter int         MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in0_mem_en,
    output logic              in0_mem_rdy,
    input  logic [31:0]       in0_mem_addr,
    input  logic [DATA_W-1:0] in0_mem_wr_data,
    input  logic [STRB_W-1:0] in0_mem_wr_byte_en,
    input  logic              in0_mem_wr_en,
    input  logic [SB_W-1:0]   in0_mem_req_sideband,
    output logic              in0_mem_rd_vld,
    input  logic              in0_mem_rd_rdy,
    output logic [DATA_W-1:0] in0_mem_rd_data,
    output logic [SB_W-1:0]   in0_mem_ack_sideband,

    output logic              out0_req_vld,
    input  logic              out0_req_rdy,
    output logic [ADDR_W-1:0] out0_req_addr,
    output logic [STRB_W-1:0] out0_req_strb,
    output logic [DATA_W-1:0] out0_req_data,
    output logic              out0_req_opcode,
    output logic [ID_W-1:0]   out0_req_src_id,
    output logic [ID_W-1:0]   out0_req_tgt_id,
    output logic [SB_W-1:0]   out0_req_sideband,

    input  logic              out0_ack_vld,
    output logic              out0_ack_rdy,
    input  logic              out0_ack_opcode,
    input  logic [DATA_W-1:0] out0_ack_data,
    input  logic [SB_W-1:0]   out0_ack_sideband,
    input  logic [ID_W-1:0]   out0_ack_src_id,
    input  logic [ID_W-1:0]   out0_ack_tgt_id,

    output logic              err_tgt_mismatch,
    output logic              err_unexp_ack,
    output logic [3:0]        rd_cnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [3:0]   rd_cnt_q, rd_cnt_d;
    logic         err_tgt_q, err_unexp_q;
    logic         credit_ok, fwd_rdy, accept;
    logic         rd_inc, rd_dec;
    logic         ack_match, ack_expected, ack_hs;
    req_payload_t req_in, req_out;

    // ---------------- request path ----------------
    assign credit_ok   = in0_mem_wr_en | (rd_cnt_q < MAX_CNT);
    assign in0_mem_rdy = fwd_rdy & credit_ok;
    assign accept      = in0_mem_en & in0_mem_rdy;

    assign req_in.addr     = word2byte(in0_mem_addr[23:0]);
    assign req_in.strb     = in0_mem_wr_byte_en;
    assign req_in.data     = in0_mem_wr_data;
    assign req_in.opcode   = in0_mem_wr_en ? OP_WR : OP_RD;
    assign req_in.sideband = in0_mem_req_sideband;

    toy_bus_fwd_reg #(.W(REQ_PAYLOAD_W)) u_fwd (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld_i   (in0_mem_en & credit_ok),
        .in_rdy_o   (fwd_rdy),
        .in_data_i  (req_in),
        .out_vld_o  (out0_req_vld),
        .out_rdy_i  (out0_req_rdy),
        .out_data_o (req_out)
    );

    assign out0_req_addr     = req_out.addr;
    assign out0_req_strb     = req_out.strb;
    assign out0_req_data     = req_out.data;
    assign out0_req_opcode   = req_out.opcode;
    assign out0_req_sideband = req_out.sideband;
    assign out0_req_src_id   = NODE_ID;
    assign out0_req_tgt_id   = TGT_ID;

    // ---------------- ack filter ----------------
    // Anything not destined for an outstanding read is swallowed so the bus never stalls on it.
    assign ack_match    = (out0_ack_tgt_id == NODE_ID);
    assign ack_expected = ack_match & (rd_cnt_q != 4'd0);
    assign out0_ack_rdy = ack_expected ? in0_mem_rd_rdy : 1'b1;
    assign ack_hs       = out0_ack_vld & out0_ack_rdy;

    assign in0_mem_rd_vld       = out0_ack_vld & ack_expected;
    assign in0_mem_rd_data      = out0_ack_data;
    assign in0_mem_ack_sideband = out0_ack_sideband;

    // ---------------- read credits ----------------
    assign rd_inc = accept & ~in0_mem_wr_en;
    assign rd_dec = ack_hs & ack_expected;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        case ({rd_inc, rd_dec})
            2'b10:   rd_cnt_d = rd_cnt_q + 4'd1;
            2'b01:   rd_cnt_d = rd_cnt_q - 4'd1;
            default: rd_cnt_d = rd_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q    <= 4'd0;
            err_tgt_q   <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            if (ack_hs & ~ack_match)
                err_tgt_q <= 1'b1;
            if (ack_hs & ack_match & (rd_cnt_q == 4'd0))
                err_unexp_q <= 1'b1;
        end
    end

    assign rd_cnt           = rd_cnt_q;
    assign err_tgt_mismatch = err_tgt_q;
    assign err_unexp_ack    = err_unexp_q;

    logic unused_ack_fields;
    assign unused_ack_fields = ^{out0_ack_opcode, out0_ack_src_id, in0_mem_addr[31:24]};

endmodule
